// File: rtl/axi_10g_ethernet_0_tcp_conn_ctrl.sv
// Passive-open TCP connection FSM for the single-port 10G TCP/IP core.
// Tracks local SEQ/ACK, IP identification and the peer address; issues one-cycle send requests.
module axi_10g_ethernet_0_tcp_conn_ctrl #(
  parameter logic [15:0] PORT           = 16'h0024,
  parameter int unsigned TIMEOUT_CYCLES = 156_250_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        rx_seg_valid,
  input  logic [7:0]  rx_seg_flags,
  input  logic [31:0] rx_seg_seq,
  input  logic [31:0] rx_seg_ack,
  input  logic [15:0] rx_seg_len,
  input  logic [31:0] rx_src_ip,
  input  logic [47:0] rx_src_mac,
  input  logic [15:0] rx_src_port,
  input  logic [15:0] rx_dst_port,
  input  logic        seq_advance_valid,
  input  logic [15:0] seq_advance_len,
  input  logic        seq_number_link_new,
  input  logic        ip_identification_link_new,
  input  logic        tcp_link_done,
  output logic        send_syn_rcvd,
  output logic        send_fin_1,
  output logic        send_fin_2,
  output logic [31:0] tx_ip,
  output logic [47:0] tx_mac,
  output logic [15:0] tx_port,
  output logic [31:0] seq_number_local,
  output logic [31:0] ack_number_local,
  output logic [15:0] ip_identification,
  output logic        conn_established
);

  typedef enum logic [2:0] {
    LISTEN,
    SYN_RCVD,
    ESTABLISHED,
    CLOSE_WAIT,
    LAST_ACK
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  state_t      state;
  logic [31:0] isn_cnt;
  logic [31:0] seq_h;
  logic [31:0] ack_h;
  logic [31:0] timer;
  logic [7:0]  retry;
  logic        busy;
  logic        id_prev;

  logic        f_fin, f_syn, f_rst, f_ack;
  logic        rx_hit, rst_evt, seg_ok, timing, expire;
  logic [31:0] rx_seq_h, rx_ack_h, seq_inc;
  logic        unused_flags;

  assign unused_flags = ^{rx_seg_flags[7:5], rx_seg_flags[3]};

  always_comb begin
    f_fin    = rx_seg_flags[0];
    f_syn    = rx_seg_flags[1];
    f_rst    = rx_seg_flags[2];
    f_ack    = rx_seg_flags[4];
    rx_seq_h = bswap32(rx_seg_seq);
    rx_ack_h = bswap32(rx_seg_ack);
    rx_hit   = rx_seg_valid && (rx_dst_port == PORT) &&
               ((state == LISTEN) || ((rx_src_ip == tx_ip) && (rx_src_port == tx_port)));
    // RST bypasses the busy drop so a reset peer cannot leave us stuck waiting on the generator
    rst_evt  = rx_hit && f_rst && (state != LISTEN);
    seg_ok   = rx_hit && !busy && !rst_evt;
    timing   = ((state == SYN_RCVD) || (state == LAST_ACK)) && !busy;
    expire   = timing && (timer == TIMER_LAST);
    seq_inc  = {31'd0, seq_number_link_new} +
               (((state == ESTABLISHED) && seq_advance_valid) ? {16'd0, seq_advance_len} : '0);
  end

  assign seq_number_local = bswap32(seq_h);
  assign ack_number_local = bswap32(ack_h);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= LISTEN;
      isn_cnt           <= '0;
      seq_h             <= '0;
      ack_h             <= '0;
      timer             <= '0;
      retry             <= '0;
      busy              <= 1'b0;
      id_prev           <= 1'b0;
      send_syn_rcvd     <= 1'b0;
      send_fin_1        <= 1'b0;
      send_fin_2        <= 1'b0;
      tx_ip             <= '0;
      tx_mac            <= '0;
      tx_port           <= '0;
      ip_identification <= '0;
      conn_established  <= 1'b0;
    end else begin
      isn_cnt       <= isn_cnt + 32'd1;
      send_syn_rcvd <= 1'b0;
      send_fin_1    <= 1'b0;
      send_fin_2    <= 1'b0;
      id_prev       <= ip_identification_link_new;
      if (ip_identification_link_new && !id_prev)
        ip_identification <= ip_identification + 16'd1;
      if (tcp_link_done)
        busy <= 1'b0;
      seq_h <= seq_h + seq_inc;
      if (timing)
        timer <= timer + 32'd1;

      if (rst_evt) begin
        state            <= LISTEN;
        busy             <= 1'b0;
        retry            <= '0;
        timer            <= '0;
        conn_established <= 1'b0;
      end else begin
        case (state)
          LISTEN: begin
            if (seg_ok && f_syn && !f_ack) begin
              tx_ip         <= rx_src_ip;
              tx_mac        <= rx_src_mac;
              tx_port       <= rx_src_port;
              seq_h         <= isn_cnt;
              ack_h         <= rx_seq_h + 32'd1;
              send_syn_rcvd <= 1'b1;
              busy          <= 1'b1;
              timer         <= '0;
              retry         <= '0;
              state         <= SYN_RCVD;
            end
          end
          SYN_RCVD: begin
            if (seg_ok && f_ack && (rx_ack_h == seq_h)) begin
              state            <= ESTABLISHED;
              conn_established <= 1'b1;
              retry            <= '0;
              timer            <= '0;
            end else if (expire) begin
              if (retry == RETRY_MAX) begin
                state <= LISTEN;
                retry <= '0;
                timer <= '0;
              end else begin
                // Rewind the number the generator consumed for the SYN so the resend is identical
                seq_h         <= seq_h + seq_inc - 32'd1;
                send_syn_rcvd <= 1'b1;
                busy          <= 1'b1;
                timer         <= '0;
                retry         <= retry + 8'd1;
              end
            end
          end
          ESTABLISHED: begin
            if (seg_ok && (rx_seq_h == ack_h)) begin
              if (f_fin) begin
                ack_h            <= ack_h + {16'd0, rx_seg_len} + 32'd1;
                send_fin_1       <= 1'b1;
                busy             <= 1'b1;
                timer            <= '0;
                conn_established <= 1'b0;
                state            <= CLOSE_WAIT;
              end else begin
                ack_h <= ack_h + {16'd0, rx_seg_len};
              end
            end
          end
          CLOSE_WAIT: begin
            if (tcp_link_done) begin
              send_fin_2 <= 1'b1;
              busy       <= 1'b1;
              timer      <= '0;
              retry      <= '0;
              state      <= LAST_ACK;
            end
          end
          LAST_ACK: begin
            if (seg_ok && f_ack && (rx_ack_h == seq_h)) begin
              state <= LISTEN;
              retry <= '0;
              timer <= '0;
            end else if (expire) begin
              if (retry == RETRY_MAX) begin
                state <= LISTEN;
                retry <= '0;
                timer <= '0;
              end else begin
                seq_h      <= seq_h + seq_inc - 32'd1;
                send_fin_2 <= 1'b1;
                busy       <= 1'b1;
                timer      <= '0;
                retry      <= retry + 8'd1;
              end
            end
          end
          default: state <= LISTEN;
        endcase
      end
    end
  end

endmodule
